// File: rtl/cpu_pkg.sv
// Shared types for the multiport accumulator CPU: opcode encoding and FSM states.
package cpu_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LDI  = 4'h1,
        OP_LD   = 4'h2,
        OP_ST   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_IN   = 4'h9,
        OP_OUT  = 4'hA,
        OP_JMP  = 4'hB,
        OP_JZ   = 4'hC,
        OP_JC   = 4'hD,
        OP_RSV  = 4'hE,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_multiport_if.sv
// I/O port bundle between the CPU (master) and its peripherals (slave).
interface cpu_multiport_if #(
    parameter int N_PORTS = 2,
    parameter int DATA_W  = 8
) ();

    logic [N_PORTS*DATA_W-1:0] in_data;
    logic [N_PORTS-1:0]        in_valid;
    logic [N_PORTS-1:0]        in_ack;
    logic [N_PORTS*DATA_W-1:0] port_out;
    logic [N_PORTS-1:0]        out_strobe;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ack,
        output port_out,
        output out_strobe
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ack,
        input  port_out,
        input  out_strobe
    );

endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU; carry is carry-out for ADD and borrow for SUB, zero otherwise.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  opcode_t           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] wide;

    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            default: wide = {1'b0, b};
        endcase
    end

    assign result = wide[DATA_W-1:0];
    assign carry  = wide[DATA_W];

endmodule

// File: rtl/cpu_multiport.sv
// Accumulator CPU with handshaked IN ports and strobed OUT ports.
//   state  | meaning
//   FETCH  | latch instr_in (ROM word at pc) into ir
//   EXEC   | execute ir, advance pc; IN stalls here until its port is valid
//   HALTED | stopped after HALT; only reset leaves
module cpu_multiport
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int N_PORTS    = 2,
    parameter int DMEM_DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [OPC_W+ADDR_W-1:0] instr_in,
    cpu_multiport_if.master         io,
    output logic [ADDR_W-1:0]       reg_pc_out,
    output logic [OPC_W-1:0]        cmd_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [DATA_W-1:0]       acc_out,
    output logic                    halted
);

    localparam int DIDX_W = $clog2(DMEM_DEPTH);
    localparam int PIDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    state_t                    state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [DATA_W-1:0]         acc_q, acc_d;
    logic                      z_q, z_d, c_q, c_d;
    logic [OPC_W+ADDR_W-1:0]   ir_q, ir_d;
    logic [N_PORTS*DATA_W-1:0] port_out_q;
    logic [N_PORTS-1:0]        strobe_q;
    logic [DATA_W-1:0]         dmem [DMEM_DEPTH];

    opcode_t                   opc;
    logic [ADDR_W-1:0]         operand;
    logic [DIDX_W-1:0]         didx;
    logic [PIDX_W-1:0]         pidx;
    logic                      port_ok;
    logic [DATA_W-1:0]         dmem_rd, in_word, alu_res;
    logic                      alu_carry, acc_wr, dmem_we, out_we;
    logic [N_PORTS-1:0]        ack;

    assign opc     = opcode_t'(ir_q[OPC_W+ADDR_W-1 -: OPC_W]);
    assign operand = ir_q[ADDR_W-1:0];
    assign didx    = operand[DIDX_W-1:0];
    assign pidx    = operand[PIDX_W-1:0];
    assign port_ok = operand < ADDR_W'(N_PORTS);
    assign dmem_rd = dmem[didx];
    assign in_word = io.in_data[pidx*DATA_W +: DATA_W];

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opc),
        .a      (acc_q),
        .b      (dmem_rd),
        .result (alu_res),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        z_d     = z_q;
        c_d     = c_q;
        ir_d    = ir_q;
        acc_wr  = 1'b0;
        dmem_we = 1'b0;
        out_we  = 1'b0;
        ack     = '0;
        case (state_q)
            FETCH: begin
                ir_d    = instr_in;
                state_d = EXEC;
            end
            EXEC: begin
                state_d = FETCH;
                pc_d    = pc_q + ADDR_W'(1);
                case (opc)
                    OP_LDI: begin acc_d = DATA_W'(operand); acc_wr = 1'b1; end
                    OP_LD:  begin acc_d = dmem_rd;          acc_wr = 1'b1; end
                    OP_ST:  dmem_we = 1'b1;
                    OP_ADD, OP_SUB: begin
                        acc_d  = alu_res;
                        c_d    = alu_carry;
                        acc_wr = 1'b1;
                    end
                    OP_AND, OP_OR, OP_XOR: begin acc_d = alu_res; acc_wr = 1'b1; end
                    OP_IN: begin
                        if (!port_ok) begin
                            acc_d  = '0;
                            acc_wr = 1'b1;
                        end else if (io.in_valid[pidx]) begin
                            acc_d     = in_word;
                            acc_wr    = 1'b1;
                            ack[pidx] = 1'b1;
                        end else begin
                            // stall: hold everything and retry next cycle
                            state_d = EXEC;
                            pc_d    = pc_q;
                        end
                    end
                    OP_OUT:  out_we = port_ok;
                    OP_JMP:  pc_d = operand;
                    OP_JZ:   if (z_q) pc_d = operand;
                    OP_JC:   if (c_q) pc_d = operand;
                    OP_HALT: state_d = HALTED;
                    default: ;
                endcase
                if (acc_wr) z_d = (acc_d == '0);
            end
            HALTED:  ;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= FETCH;
            pc_q       <= '0;
            acc_q      <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            ir_q       <= '0;
            port_out_q <= '0;
            strobe_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            acc_q    <= acc_d;
            z_q      <= z_d;
            c_q      <= c_d;
            ir_q     <= ir_d;
            strobe_q <= '0;
            if (out_we) begin
                port_out_q[pidx*DATA_W +: DATA_W] <= acc_q;
                strobe_q[pidx]                    <= 1'b1;
            end
        end
    end

    // data memory keeps its contents across reset
    always_ff @(posedge clock) begin
        if (reset && dmem_we) dmem[didx] <= acc_q;
    end

    // ack is only meaningful while not in reset, since the consume is suppressed then
    assign io.in_ack     = ack & {N_PORTS{reset}};
    assign io.port_out   = port_out_q;
    assign io.out_strobe = strobe_q;
    assign reg_pc_out    = pc_q;
    assign cmd_out       = ir_q[OPC_W+ADDR_W-1 -: OPC_W];
    assign addr_out      = operand;
    assign acc_out       = acc_q;
    assign halted        = (state_q == HALTED);

endmodule

// File: tb/tb_cpu_multiport.sv
// Self-checking bench for cpu_multiport: ROM model, scoreboard of expected OUT events, direct checks.
module tb_cpu_multiport;
    import cpu_pkg::*;

    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 8;
    localparam int N_PORTS    = 2;
    localparam int DMEM_DEPTH = 16;

    typedef struct {
        int          port;
        logic [7:0]  val;
    } exp_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [OPC_W+ADDR_W-1:0] instr_in;
    logic [ADDR_W-1:0]       reg_pc_out, addr_out;
    logic [OPC_W-1:0]        cmd_out;
    logic [DATA_W-1:0]       acc_out;
    logic                    halted;
    logic [11:0]             rom [256];
    exp_t                    sb[$];
    int                      n_vec = 0;
    int                      n_err = 0;

    cpu_multiport_if #(.N_PORTS(N_PORTS), .DATA_W(DATA_W)) io ();

    cpu_multiport #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_PORTS(N_PORTS), .DMEM_DEPTH(DMEM_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .instr_in   (instr_in),
        .io         (io),
        .reg_pc_out (reg_pc_out),
        .cmd_out    (cmd_out),
        .addr_out   (addr_out),
        .acc_out    (acc_out),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    assign instr_in = rom[reg_pc_out];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ins(input logic [3:0] op, input logic [7:0] a);
        return {op, a};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 8'h00);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_val("rst_pc",       reg_pc_out,  0);
        check_val("rst_acc",      acc_out,     0);
        check_val("rst_cmd",      cmd_out,     0);
        check_val("rst_addr",     addr_out,    0);
        check_val("rst_halted",   halted,      0);
        check_val("rst_in_ack",   io.in_ack,   0);
        check_val("rst_strobe",   io.out_strobe, 0);
        check_val("rst_port_out", io.port_out, 0);
    endtask

    task automatic release_reset();
        reset = 1'b1;
        #1;
        check_val("fetch0_pc", reg_pc_out, 0);
    endtask

    // scoreboard: every OUT strobe must match the next expected {port, value}
    always @(negedge clock) begin
        for (int k = 0; k < N_PORTS; k++) begin
            if (io.out_strobe[k]) begin
                exp_t e;
                if (sb.size() == 0) begin
                    check_val("unexpected_strobe", k, 99);
                end else begin
                    e = sb.pop_front();
                    check_val("out_port",  k, e.port);
                    check_val("out_value", io.port_out[k*DATA_W +: DATA_W], e.val);
                end
            end
        end
    end

    initial begin
        io.in_data  = '0;
        io.in_valid = '0;

        // LDI 0x0A; ST 1; ADD 1; OUT 0; HALT
        clear_rom();
        rom[0] = ins(OP_LDI, 8'h0A);
        rom[1] = ins(OP_ST,  8'h01);
        rom[2] = ins(OP_ADD, 8'h01);
        rom[3] = ins(OP_OUT, 8'h00);
        apply_reset();
        sb.push_back('{0, 8'h14});
        release_reset();
        tick(1);
        check_val("exec0_pc", reg_pc_out, 0);
        tick(1);
        check_val("pc_after_1st", reg_pc_out, 1);
        tick(6);
        check_val("out0_strobe_on", io.out_strobe, 2'b01);
        check_val("out0_value", io.port_out[7:0], 8'h14);
        tick(1);
        check_val("out0_strobe_off", io.out_strobe, 2'b00);
        check_val("out0_hold", io.port_out[7:0], 8'h14);
        tick(4);
        check_val("halt_a", halted, 1);
        check_val("halt_cmd", cmd_out, OP_HALT);

        // reset out of HALTED; then carry/zero and jumps
        clear_rom();
        rom[8'h00] = ins(OP_LDI, 8'hFF);
        rom[8'h01] = ins(OP_ST,  8'h01);
        rom[8'h02] = ins(OP_LDI, 8'h01);
        rom[8'h03] = ins(OP_ADD, 8'h01);
        rom[8'h04] = ins(OP_JC,  8'h20);
        rom[8'h20] = ins(OP_JZ,  8'h30);
        rom[8'h30] = ins(OP_SUB, 8'h01);
        rom[8'h31] = ins(OP_OUT, 8'h01);
        rom[8'h32] = ins(OP_JC,  8'h40);
        rom[8'h40] = ins(OP_NOP, 8'h00);
        apply_reset();
        sb.push_back('{1, 8'h01});
        release_reset();
        tick(8);
        check_val("add_wrap_acc", acc_out, 8'h00);
        tick(2);
        check_val("jc_taken_pc", reg_pc_out, 8'h20);
        tick(2);
        check_val("jz_taken_pc", reg_pc_out, 8'h30);
        tick(2);
        check_val("sub_borrow_acc", acc_out, 8'h01);
        tick(2);
        check_val("out1_strobe", io.out_strobe, 2'b10);
        check_val("out1_port0_hold", io.port_out[7:0], 8'h00);
        tick(2);
        check_val("jc_borrow_pc", reg_pc_out, 8'h40);
        tick(4);
        check_val("halt_b", halted, 1);

        // IN stall, IN/OUT on nonexistent port, logic ops
        clear_rom();
        rom[8'h00] = ins(OP_IN,  8'h01);
        rom[8'h01] = ins(OP_ST,  8'h02);
        rom[8'h02] = ins(OP_IN,  8'h03);
        rom[8'h03] = ins(OP_JZ,  8'h05);
        rom[8'h05] = ins(OP_OUT, 8'h03);
        rom[8'h06] = ins(OP_LDI, 8'h3C);
        rom[8'h07] = ins(OP_ST,  8'h03);
        rom[8'h08] = ins(OP_LD,  8'h02);
        rom[8'h09] = ins(OP_OR,  8'h03);
        rom[8'h0A] = ins(OP_OUT, 8'h00);
        rom[8'h0B] = ins(OP_XOR, 8'h03);
        rom[8'h0C] = ins(OP_OR,  8'h02);
        rom[8'h0D] = ins(OP_AND, 8'h03);
        rom[8'h0E] = ins(OP_OUT, 8'h01);
        apply_reset();
        io.in_data  = {8'h0A, 8'h55};
        io.in_valid = 2'b01;
        sb.push_back('{0, 8'h3E});
        sb.push_back('{1, 8'h08});
        release_reset();
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check_val("stall_pc",  reg_pc_out, 0);
            check_val("stall_ack", io.in_ack,  0);
            check_val("stall_acc", acc_out,    0);
            tick(1);
        end
        io.in_valid[1] = 1'b1;
        #1;
        check_val("in1_ack_pulse", io.in_ack, 2'b10);
        tick(1);
        io.in_valid[1] = 1'b0;
        check_val("in1_acc", acc_out, 8'h0A);
        check_val("in1_pc_adv", reg_pc_out, 1);
        check_val("in1_ack_off", io.in_ack, 0);
        tick(3);
        check_val("in3_no_ack", io.in_ack, 0);
        check_val("in3_pc", reg_pc_out, 2);
        tick(1);
        check_val("in3_acc", acc_out, 0);
        check_val("in3_no_stall_pc", reg_pc_out, 3);
        tick(4);
        check_val("out3_no_strobe", io.out_strobe, 0);
        check_val("out3_port_out", io.port_out, 0);
        tick(30);
        check_val("halt_c", halted, 1);

        // reset in the middle of an IN stall, with valid asserted during reset
        apply_reset();
        release_reset();
        tick(3);
        check_val("stall2_pc", reg_pc_out, 0);
        io.in_valid[1] = 1'b1;
        apply_reset();
        sb.push_back('{0, 8'h3E});
        sb.push_back('{1, 8'h08});
        release_reset();
        tick(1);
        check_val("restart_ack", io.in_ack, 2'b10);
        tick(1);
        io.in_valid[1] = 1'b0;
        check_val("restart_acc", acc_out, 8'h0A);
        tick(30);
        check_val("halt_d", halted, 1);

        tick(2);
        check_val("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
